// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the round-robin channel scanner.
package scan_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DWELL = 2'd2
    } scan_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request strictly after `last`,
// wrapping through all eight positions (so req[last] alone is still found).
module rr_pick8
    import scan_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] start;
    logic [N_CH-1:0]  rot;
    logic [SEL_W-1:0] off;

    assign start = last + SEL_W'(1);

    // rot[0] is the highest-priority position; 3-bit index arithmetic wraps mod 8.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
            assign rot[gi] = req[start + SEL_W'(gi)];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = SEL_W'(j);
            end
        end
    end

    assign idx = start + off;

endmodule

// File: rtl/scan_sel_gen.sv
// Round-robin channel scanner producing the registered select/enable pair
// for the 3-to-8 decoder, holding each grant for a programmable dwell.
module scan_sel_gen
    import scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [7:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_en,
    output logic               done,
    output logic               busy
);

    scan_state_t        state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               sel_en_q, sel_en_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;

    rr_pick8 u_pick (
        .req   (req),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    // A dwell of 0 behaves as 1: the counter starts at 0 either way.
                    cnt_d   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                    state_d = DWELL;
                end else if (!run) begin
                    state_d = IDLE;
                end
            end
            DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    last_d  = sel_q;
                    state_d = run ? ARB : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state view, so they line up
        // with the state they describe without any input-to-output path.
        sel_en_d = (state_d == DWELL);
        done_d   = (state_d == DWELL) && (cnt_d == '0);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            last_q   <= SEL_W'(N_CH - 1);
            cnt_q    <= '0;
            sel_en_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            sel_en_q <= sel_en_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign sel    = sel_q;
    assign sel_en = sel_en_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed self-checking bench for scan_sel_gen with a 3-to-8 decoder on its outputs.
module tb_scan_sel_gen;

    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] req;
    logic [3:0] dwell;
    logic [2:0] sel;
    logic       sel_en;
    logic       done;
    logic       busy;
    logic [7:0] dec_y;

    int n_checks = 0;
    int n_fail   = 0;

    scan_sel_gen #(.DWELL_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .req    (req),
        .dwell  (dwell),
        .sel    (sel),
        .sel_en (sel_en),
        .done   (done),
        .busy   (busy)
    );

    // Downstream 3-to-8 decoder with enable.
    always_comb begin
        dec_y = 8'h00;
        if (sel_en) begin
            dec_y[sel] = 1'b1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One full grant of channel ch lasting d cycles, then the guard ARB cycle.
    task automatic grant(input int ch, input int d);
        logic [7:0] onehot;
        onehot = 8'h01 << ch;
        for (int k = 1; k <= d; k++) begin
            step();
            check($sformatf("ch%0d_sel_c%0d", ch, k), 32'(sel), 32'(ch));
            check($sformatf("ch%0d_en_c%0d", ch, k), 32'(sel_en), 32'd1);
            check($sformatf("ch%0d_done_c%0d", ch, k), 32'(done), 32'(k == d));
            check($sformatf("ch%0d_dec_c%0d", ch, k), 32'(dec_y), 32'(onehot));
        end
        step();
        check($sformatf("ch%0d_gap_en", ch), 32'(sel_en), 32'd0);
        check($sformatf("ch%0d_gap_done", ch), 32'(done), 32'd0);
        check($sformatf("ch%0d_gap_dec", ch), 32'(dec_y), 32'd0);
        check($sformatf("ch%0d_gap_busy", ch), 32'(busy), 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        run   = 1'b0;
        req   = 8'h00;
        dwell = 4'd0;
        step();
        step();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_en", 32'(sel_en), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Full sweep: 0..7 then wrap to 0, dwell 2.
        run   = 1'b1;
        req   = 8'hFF;
        dwell = 4'd2;
        step();
        check("arb_busy", 32'(busy), 32'd1);
        check("arb_en", 32'(sel_en), 32'd0);
        for (int c = 0; c < 9; c++) begin
            grant(c % 8, 2);
        end

        // Sparse requests alternate 2,7; dwell 0 behaves as dwell 1.
        req   = 8'b1000_0100;
        dwell = 4'd1;
        grant(2, 1);
        grant(7, 1);
        grant(2, 1);
        grant(7, 1);
        dwell = 4'd0;
        grant(2, 1);
        grant(7, 1);

        // Drop req and run mid-dwell: full 5 cycles still served, then IDLE.
        req   = 8'h08;
        dwell = 4'd5;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("mid_sel_c%0d", k), 32'(sel), 32'd3);
            check($sformatf("mid_en_c%0d", k), 32'(sel_en), 32'd1);
            check($sformatf("mid_done_c%0d", k), 32'(done), 32'(k == 5));
            if (k == 2) begin
                req = 8'h00;
                run = 1'b0;
            end
        end
        step();
        check("mid_idle_busy", 32'(busy), 32'd0);
        check("mid_idle_en", 32'(sel_en), 32'd0);
        step();
        check("mid_idle_hold", 32'(busy), 32'd0);

        // No requests: hold in ARB until one appears.
        run = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("noreq_busy_%0d", k), 32'(busy), 32'd1);
            check($sformatf("noreq_en_%0d", k), 32'(sel_en), 32'd0);
        end
        req   = 8'h10;
        dwell = 4'd1;
        step();
        check("noreq_sel", 32'(sel), 32'd4);
        check("noreq_en", 32'(sel_en), 32'd1);
        check("noreq_done", 32'(done), 32'd1);

        // Asynchronous reset in the middle of a dwell.
        req   = 8'hFF;
        dwell = 4'd5;
        step();
        check("pre_rst_gap", 32'(sel_en), 32'd0);
        step();
        check("pre_rst_sel", 32'(sel), 32'd5);
        step();
        check("pre_rst_en", 32'(sel_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_en", 32'(sel_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_arb", 32'(busy), 32'd1);
        grant(0, 5);

        // Maximum dwell gives exactly 15 enable cycles.
        dwell = 4'd15;
        grant(1, 15);

        // Single requester, which is also req[last] after its first grant.
        req   = 8'h40;
        dwell = 4'd1;
        grant(6, 1);
        grant(6, 1);
        grant(6, 1);

        run = 1'b0;
        req = 8'h00;
        step();
        check("end_idle_busy", 32'(busy), 32'd0);
        check("end_idle_dec", 32'(dec_y), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
